// File: rtl/mul_64b_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the shared 64x64 multiplier.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface mul_64b_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [64*NUM_REQ-1:0] req_a;
  logic [64*NUM_REQ-1:0] req_b;
  logic [63:0]           mul_a;
  logic [63:0]           mul_b;
  logic [127:0]          mul_p;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [127:0]          rsp_p;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_p, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_p, busy
  );
endinterface

// File: rtl/mul_64b_arbiter.sv
// Round-robin front end for one shared 64x64 multiplier: grants one operand pair per
// cycle, follows each product with a one-hot tag and returns it to its issuer.
module mul_64b_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_64b_arbiter_if.slave     bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [NUM_REQ-1:0] tag_t;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   scan;
  logic             found;
  tag_t             grant;

  logic [63:0]  a_vec [NUM_REQ];
  logic [63:0]  b_vec [NUM_REQ];
  logic [63:0]  mul_a_q, mul_a_d;
  logic [63:0]  mul_b_q, mul_b_d;
  tag_t         tag_q [MUL_LAT+1];
  tag_t         tag_d [MUL_LAT+1];
  tag_t         rsp_valid_q, rsp_valid_d;
  logic [127:0] rsp_p_q, rsp_p_d;
  logic         busy_c;

  // Scan from the pointer with wrap; the first valid requester wins. Reset blocks grants.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!found && !rst && bus.req_valid[scan[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan[PTR_W-1:0];
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_vec[i] = bus.req_a[64*i +: 64];
      b_vec[i] = bus.req_b[64*i +: 64];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    // Operands only move on a grant so the multiplier sees no toggling while idle.
    if (found) begin
      ptr_d   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      mul_a_d = a_vec[grant_idx];
      mul_b_d = b_vec[grant_idx];
    end
    tag_d[0] = grant;
    for (int i = 1; i <= MUL_LAT; i++) tag_d[i] = tag_q[i-1];
    // The last tag stage lines up with mul_p; capture the product only when it is real.
    rsp_valid_d = tag_q[MUL_LAT];
    rsp_p_d     = (|tag_q[MUL_LAT]) ? bus.mul_p : rsp_p_q;
  end

  always_comb begin
    busy_c = |rsp_valid_q;
    for (int i = 0; i <= MUL_LAT; i++) busy_c = busy_c | (|tag_q[i]);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      // NOTE: the tag pipeline is reset because its contents are valid bits; dropping
      // them is what cancels every in-flight product.
      for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_mul_64b_arbiter.sv
// Drives a combinational-multiplier instance and a 3-cycle-multiplier instance with the
// same requests and compares both against a cycle-indexed reference model.
module tb_mul_64b_arbiter;
  localparam int N   = 4;
  localparam int CYC = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   vld;
  logic [63:0]    op_a [N];
  logic [63:0]    op_b [N];
  logic [64*N-1:0] pa, pb;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pa[64*i +: 64] = op_a[i];
      pb[64*i +: 64] = op_b[i];
    end
  end

  mul_64b_arbiter_if #(.NUM_REQ(N)) if0 ();
  mul_64b_arbiter_if #(.NUM_REQ(N)) if3 ();

  assign if0.req_valid = vld;
  assign if0.req_a     = pa;
  assign if0.req_b     = pb;
  assign if3.req_valid = vld;
  assign if3.req_a     = pa;
  assign if3.req_b     = pb;

  // Behavioural multipliers: combinational, and three registers deep.
  logic [127:0] p1, p2, p3;
  assign if0.mul_p = {64'b0, if0.mul_a} * {64'b0, if0.mul_b};
  always @(posedge clk) begin
    p1 <= {64'b0, if3.mul_a} * {64'b0, if3.mul_b};
    p2 <= p1;
    p3 <= p2;
  end
  assign if3.mul_p = p3;

  mul_64b_arbiter #(.NUM_REQ(N), .MUL_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mul_64b_arbiter #(.NUM_REQ(N), .MUL_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [N-1:0]  rdy_o [2];
  logic [N-1:0]  rv_o  [2];
  logic [127:0]  rp_o  [2];
  logic [63:0]   ma_o  [2];
  logic [63:0]   mb_o  [2];
  logic          bz_o  [2];
  assign rdy_o[0] = if0.req_ready;  assign rdy_o[1] = if3.req_ready;
  assign rv_o[0]  = if0.rsp_valid;  assign rv_o[1]  = if3.rsp_valid;
  assign rp_o[0]  = if0.rsp_p;      assign rp_o[1]  = if3.rsp_p;
  assign ma_o[0]  = if0.mul_a;      assign ma_o[1]  = if3.mul_a;
  assign mb_o[0]  = if0.mul_b;      assign mb_o[1]  = if3.mul_b;
  assign bz_o[0]  = if0.busy;       assign bz_o[1]  = if3.busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: expected responses are scheduled by absolute cycle number.
  int           lat [2] = '{0, 3};
  bit [N-1:0]   exp_v [2][CYC];
  logic [127:0] exp_p [2][CYC];
  bit           gnt_at [CYC];
  logic [127:0] rsp_m [2];
  logic [63:0]  ma_m, mb_m;
  int           ptr_m;
  int           cyc;
  int           gnt_m;
  int           obs_g;
  logic [N-1:0] obs_rv [2];
  logic         obs_bz [2];

  function automatic logic [N-1:0] onehot(input int g);
    return N'(1) << g;
  endfunction

  task automatic run_cycle();
    bit           busy_e;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    if (cyc + 12 >= CYC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, CYC - 12);
      $fatal(1, "cycle budget exhausted");
    end
    for (int d = 0; d < 2; d++) begin
      if (exp_v[d][cyc] != '0) rsp_m[d] = exp_p[d][cyc];
      busy_e = 1'b0;
      for (int g = cyc - 2 - lat[d]; g < cyc; g++)
        if (g >= 0 && gnt_at[g]) busy_e = 1'b1;
      check($sformatf("rsp_valid[L%0d]", lat[d]), rv_o[d], exp_v[d][cyc]);
      check($sformatf("rsp_p[L%0d]", lat[d]), rp_o[d], rsp_m[d]);
      check($sformatf("busy[L%0d]", lat[d]), bz_o[d], busy_e);
      check($sformatf("mul_a[L%0d]", lat[d]), ma_o[d], ma_m);
      check($sformatf("mul_b[L%0d]", lat[d]), mb_o[d], mb_m);
      obs_rv[d] = rv_o[d];
      obs_bz[d] = bz_o[d];
    end
    gnt_m = -1;
    if (!rst)
      for (int k = 0; k < N; k++)
        if (gnt_m < 0 && vld[(ptr_m + k) % N]) gnt_m = (ptr_m + k) % N;
    exp_rdy = (gnt_m < 0) ? '0 : onehot(gnt_m);
    check("req_ready[L0]", rdy_o[0], exp_rdy);
    check("req_ready[L3]", rdy_o[1], exp_rdy);
    obs_g = -1;
    for (int i = 0; i < N; i++) if (rdy_o[0][i]) obs_g = i;
    @(posedge clk);
    if (rst) begin
      ptr_m = 0;
      ma_m  = '0;
      mb_m  = '0;
      for (int d = 0; d < 2; d++) begin
        rsp_m[d] = '0;
        for (int c = cyc + 1; c < CYC; c++) exp_v[d][c] = '0;
      end
      for (int c = 0; c < CYC; c++) gnt_at[c] = 1'b0;
    end else if (gnt_m >= 0) begin
      ptr_m = (gnt_m + 1) % N;
      ma_m  = op_a[gnt_m];
      mb_m  = op_b[gnt_m];
      gnt_at[cyc] = 1'b1;
      for (int d = 0; d < 2; d++) begin
        exp_v[d][cyc + 2 + lat[d]] = onehot(gnt_m);
        exp_p[d][cyc + 2 + lat[d]] = {64'b0, op_a[gnt_m]} * {64'b0, op_b[gnt_m]};
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    vld = '0;
    repeat (n) run_cycle();
  endtask

  int  hit;
  bit  seen_rv;

  initial begin
    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    ptr_m = 0; ma_m = '0; mb_m = '0; rsp_m[0] = '0; rsp_m[1] = '0; cyc = 0; gnt_m = -1;
    run_cycle();               // reset values visible, req_ready forced low
    rst = 1'b0;

    // Single request, product 15
    op_a[0] = 64'h3; op_b[0] = 64'h5; vld = 4'b0001;
    run_cycle();
    check("t1_grant", obs_g, 0);
    vld = '0;
    check("t1_mul_a", ma_o[0], 64'h3);
    check("t1_mul_b", mb_o[0], 64'h5);
    run_cycle();
    run_cycle();
    check("t1_rsp_valid", obs_rv[0], 4'b0001);
    check("t1_rsp_p", rp_o[0], 128'd15);
    run_cycle();
    check("t1_busy_low", obs_bz[0], 1'b0);
    idle(4);

    // Full-width operands on requester 2
    op_a[2] = '1; op_b[2] = '1; vld = 4'b0100;
    run_cycle();
    check("t2_grant", obs_g, 2);
    idle(6);
    check("t2_rsp_p[L0]", rp_o[0], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    check("t2_rsp_p[L3]", rp_o[1], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Latency 3 lands exactly 5 cycles after the handshake
    op_a[1] = 64'd7; op_b[1] = 64'd9; vld = 4'b0010;
    run_cycle();
    vld = '0;
    hit = -1;
    for (int j = 1; j <= 7; j++) begin
      run_cycle();
      if (obs_rv[1] == 4'b0010 && hit < 0) hit = j;
    end
    check("t4_latency", hit, 5);
    check("t4_rsp_p", rp_o[1], 128'd63);

    // Sparse traffic: req1, idle, req0, then all valid goes to req1
    op_a[1] = 64'h1111; op_b[1] = 64'h2222; vld = 4'b0010;
    run_cycle();
    idle(3);
    check("t6_hold_a", ma_o[0], 64'h1111);
    op_a[0] = 64'hABCD; op_b[0] = 64'h10; vld = 4'b0001;
    run_cycle();
    check("t6_grant0", obs_g, 0);
    vld = 4'b1111;
    run_cycle();
    check("t6_next_is_1", obs_g, 1);
    idle(6);

    // Reset mid-flight cancels the req3 product
    op_a[3] = 64'hDEAD; op_b[3] = 64'hBEEF; vld = 4'b1000;
    run_cycle();
    check("t5_grant3", obs_g, 3);
    vld = '0; rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    seen_rv = 1'b0;
    for (int j = 0; j < 6; j++) begin
      run_cycle();
      if (obs_rv[0] != '0 || obs_rv[1] != '0) seen_rv = 1'b1;
    end
    check("t5_no_rsp", seen_rv, 1'b0);
    check("t5_busy", obs_bz[1], 1'b0);

    // All four valid from pointer 0: strict rotation
    for (int i = 0; i < N; i++) begin
      op_a[i] = 64'(i + 2) << (8 * i);
      op_b[i] = 64'h1_0000_0001 * 64'(i + 3);
    end
    vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      check($sformatf("t3_seq%0d", k), obs_g, k % N);
    end
    idle(6);

    // Randomized traffic with operands held stable until granted
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (vld[i] && gnt_m != i) begin
          if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
        end else begin
          vld[i] = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 7) == 0) begin
            op_a[i] = '1; op_b[i] = '1;
          end else begin
            op_a[i] = {$urandom, $urandom};
            op_b[i] = {$urandom, $urandom};
          end
        end
      end
      run_cycle();
    end
    rst = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
